// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if -- bundle between the ID stage and the ID/EX pipeline register.
//
// Purpose: carries the decoded ID-side instruction (datapath fields and
// control bits) into the pipeline register, and the registered EX-side
// copies (*_store, ex_valid) back out to the execute stage.
//
// Modports:
//   master : ID-side driver; drives the ID fields, observes the EX copies.
//   slave  : pipeline register; consumes the ID fields, drives the EX copies.
interface id_ex_pipe_if #(
  parameter int XLEN   = 64,
  parameter int REGW   = 5,
  parameter int FUNCTW = 4,
  parameter int ALUOPW = 2
) ();

  // ID-side instruction
  logic              id_valid;
  logic [XLEN-1:0]   PC_addr;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;
  logic [XLEN-1:0]   imm_val;
  logic [FUNCTW-1:0] funct_in;
  logic [ALUOPW-1:0] ALU_op;
  logic [REGW-1:0]   rd_in;
  logic [REGW-1:0]   rs1_in;
  logic [REGW-1:0]   rs2_in;
  logic              MemtoReg;
  logic              RegWrite;
  logic              Branch;
  logic              MemWrite;
  logic              MemRead;
  logic              ALUSrc;

  // EX-side registered copies
  logic              ex_valid;
  logic [XLEN-1:0]   PC_addr_store;
  logic [XLEN-1:0]   read_data1_store;
  logic [XLEN-1:0]   read_data2_store;
  logic [XLEN-1:0]   imm_val_store;
  logic [FUNCTW-1:0] funct_in_store;
  logic [ALUOPW-1:0] ALU_op_store;
  logic [REGW-1:0]   rd_in_store;
  logic [REGW-1:0]   rs1_in_store;
  logic [REGW-1:0]   rs2_in_store;
  logic              MemtoReg_store;
  logic              RegWrite_store;
  logic              Branch_store;
  logic              MemWrite_store;
  logic              MemRead_store;
  logic              ALUSrc_store;

  modport master (
    output id_valid, PC_addr, read_data1, read_data2, imm_val, funct_in, ALU_op,
           rd_in, rs1_in, rs2_in, MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc,
    input  ex_valid, PC_addr_store, read_data1_store, read_data2_store, imm_val_store,
           funct_in_store, ALU_op_store, rd_in_store, rs1_in_store, rs2_in_store,
           MemtoReg_store, RegWrite_store, Branch_store, MemWrite_store, MemRead_store,
           ALUSrc_store
  );

  modport slave (
    input  id_valid, PC_addr, read_data1, read_data2, imm_val, funct_in, ALU_op,
           rd_in, rs1_in, rs2_in, MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc,
    output ex_valid, PC_addr_store, read_data1_store, read_data2_store, imm_val_store,
           funct_in_store, ALU_op_store, rd_in_store, rs1_in_store, rs2_in_store,
           MemtoReg_store, RegWrite_store, Branch_store, MemWrite_store, MemRead_store,
           ALUSrc_store
  );

endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe -- ID/EX pipeline register with load-use hazard detection.
//
// Purpose: registers the decoded instruction between ID and EX, inserts a
// one-cycle bubble on a load-use hazard, kills the entering instruction on
// flush, freezes on a downstream stall, and counts bubbles and flushes.
//
// Ports:
//   clk           : single clock, rising edge
//   reset         : synchronous, active-high
//   flush         : kill the instruction entering EX (taken branch)
//   stall_ext     : downstream hold, EX register keeps its contents
//   bus           : id_ex_pipe_if.slave, ID fields in / *_store + ex_valid out
//   hold_upstream : combinational, PC and IF/ID must not advance
//   load_use      : combinational, load-use hazard this cycle
//   bubble_cnt    : saturating count of inserted bubbles
//   flush_cnt     : saturating count of flushes
module id_ex_pipe #(
  parameter int XLEN   = 64,
  parameter int REGW   = 5,
  parameter int FUNCTW = 4,
  parameter int ALUOPW = 2,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall_ext,
  id_ex_pipe_if.slave      bus,
  output logic             hold_upstream,
  output logic             load_use,
  output logic [CNTW-1:0]  bubble_cnt,
  output logic [CNTW-1:0]  flush_cnt
);

  // Control bits packed as {MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc}
  localparam int CTLW = 6;
  localparam int CTL_MEMREAD = 1;

  logic [CTLW-1:0]   ctl_in;
  logic [CTLW-1:0]   ctl_q,       ctl_d;
  logic              valid_q,     valid_d;
  logic [XLEN-1:0]   pc_q,        pc_d;
  logic [XLEN-1:0]   rdata1_q,    rdata1_d;
  logic [XLEN-1:0]   rdata2_q,    rdata2_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic [FUNCTW-1:0] funct_q,     funct_d;
  logic [ALUOPW-1:0] aluop_q,     aluop_d;
  logic [REGW-1:0]   rd_q,        rd_d;
  logic [REGW-1:0]   rs1_q,       rs1_d;
  logic [REGW-1:0]   rs2_q,       rs2_d;
  logic [CNTW-1:0]   bubble_q,    bubble_d;
  logic [CNTW-1:0]   flushc_q,    flushc_d;
  logic              hazard;

  assign ctl_in = {bus.MemtoReg, bus.RegWrite, bus.Branch,
                   bus.MemWrite, bus.MemRead, bus.ALUSrc};

  // x0 is never a real destination, so a load into x0 cannot create a hazard.
  assign hazard = valid_q & ctl_q[CTL_MEMREAD] & bus.id_valid & (rd_q != '0) &
                  ((rd_q == bus.rs1_in) | (rd_q == bus.rs2_in));

  assign load_use      = hazard;
  // A flush discards the ID instruction anyway, so upstream may advance.
  assign hold_upstream = (stall_ext | hazard) & ~flush;

  always_comb begin
    ctl_d    = ctl_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    funct_d  = funct_q;
    aluop_d  = aluop_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    bubble_d = bubble_q;
    flushc_d = flushc_q;

    if (flush) begin
      ctl_d    = '0;
      valid_d  = 1'b0;
      pc_d     = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      funct_d  = '0;
      aluop_d  = '0;
      rd_d     = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      flushc_d = (flushc_q == {CNTW{1'b1}}) ? flushc_q : flushc_q + 1'b1;
    end else if (stall_ext) begin
      // hold: defaults keep every register
    end else begin
      // Datapath fields follow the ID stage for both bubble and load.
      pc_d     = bus.PC_addr;
      rdata1_d = bus.read_data1;
      rdata2_d = bus.read_data2;
      imm_d    = bus.imm_val;
      funct_d  = bus.funct_in;
      rd_d     = bus.rd_in;
      rs1_d    = bus.rs1_in;
      rs2_d    = bus.rs2_in;
      if (hazard) begin
        ctl_d    = '0;
        aluop_d  = '0;
        valid_d  = 1'b0;
        bubble_d = (bubble_q == {CNTW{1'b1}}) ? bubble_q : bubble_q + 1'b1;
      end else begin
        // An invalid slot must never write the register file or memory.
        ctl_d   = bus.id_valid ? ctl_in : '0;
        aluop_d = bus.ALU_op;
        valid_d = bus.id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q    <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      funct_q  <= '0;
      aluop_q  <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      bubble_q <= '0;
      flushc_q <= '0;
    end else begin
      ctl_q    <= ctl_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      funct_q  <= funct_d;
      aluop_q  <= aluop_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      bubble_q <= bubble_d;
      flushc_q <= flushc_d;
    end
  end

  assign bus.ex_valid         = valid_q;
  assign bus.PC_addr_store    = pc_q;
  assign bus.read_data1_store = rdata1_q;
  assign bus.read_data2_store = rdata2_q;
  assign bus.imm_val_store    = imm_q;
  assign bus.funct_in_store   = funct_q;
  assign bus.ALU_op_store     = aluop_q;
  assign bus.rd_in_store      = rd_q;
  assign bus.rs1_in_store     = rs1_q;
  assign bus.rs2_in_store     = rs2_q;
  assign bus.MemtoReg_store   = ctl_q[5];
  assign bus.RegWrite_store   = ctl_q[4];
  assign bus.Branch_store     = ctl_q[3];
  assign bus.MemWrite_store   = ctl_q[2];
  assign bus.MemRead_store    = ctl_q[1];
  assign bus.ALUSrc_store     = ctl_q[0];

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flushc_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe -- directed vectors with a queue-based scoreboard.
//
// Each stimulus step drives the ID inputs just after a rising edge and pushes
// a record holding the expected combinational outputs for those inputs and
// the expected registered outputs after the next edge. The monitor pops one
// record per falling edge and compares. A second instance with CNTW=2 shares
// all inputs and shows flush counter saturation.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  logic reset, flush, stall_ext;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.XLEN(64), .REGW(5), .FUNCTW(4), .ALUOPW(2)) bus ();
  id_ex_pipe_if #(.XLEN(64), .REGW(5), .FUNCTW(4), .ALUOPW(2)) bus_s ();

  logic        hold_upstream, load_use;
  logic [15:0] bubble_cnt, flush_cnt;
  logic        hold_s, lu_s;
  logic [1:0]  bubble_s, flush_s;

  id_ex_pipe #(.XLEN(64), .REGW(5), .FUNCTW(4), .ALUOPW(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_ext(stall_ext), .bus(bus),
    .hold_upstream(hold_upstream), .load_use(load_use),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe #(.XLEN(64), .REGW(5), .FUNCTW(4), .ALUOPW(2), .CNTW(2)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .stall_ext(stall_ext), .bus(bus_s),
    .hold_upstream(hold_s), .load_use(lu_s),
    .bubble_cnt(bubble_s), .flush_cnt(flush_s)
  );

  assign bus_s.id_valid   = bus.id_valid;
  assign bus_s.PC_addr    = bus.PC_addr;
  assign bus_s.read_data1 = bus.read_data1;
  assign bus_s.read_data2 = bus.read_data2;
  assign bus_s.imm_val    = bus.imm_val;
  assign bus_s.funct_in   = bus.funct_in;
  assign bus_s.ALU_op     = bus.ALU_op;
  assign bus_s.rd_in      = bus.rd_in;
  assign bus_s.rs1_in     = bus.rs1_in;
  assign bus_s.rs2_in     = bus.rs2_in;
  assign bus_s.MemtoReg   = bus.MemtoReg;
  assign bus_s.RegWrite   = bus.RegWrite;
  assign bus_s.Branch     = bus.Branch;
  assign bus_s.MemWrite   = bus.MemWrite;
  assign bus_s.MemRead    = bus.MemRead;
  assign bus_s.ALUSrc     = bus.ALUSrc;

  typedef struct {
    int          idx;
    logic        last;
    logic        lu;
    logic        hold;
    logic        ev;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [1:0]  alu;
    logic [15:0] bc;
    logic [15:0] fc;
    logic [1:0]  fcs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  logic mon_done = 1'b0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of ID inputs and queue its expectations.
  task automatic step(input logic rst, input logic fl, input logic st, input logic v,
                      input logic [63:0] pc, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [5:0] ctl, input logic [1:0] alu,
                      input logic e_lu, input logic e_hold,
                      input logic e_ev, input logic [63:0] e_pc, input logic [4:0] e_rd,
                      input logic [5:0] e_ctl, input logic [1:0] e_alu,
                      input int e_bc, input int e_fc, input int e_fcs);
    exp_t r;
    @(posedge clk);
    #1;
    reset        = rst;
    flush        = fl;
    stall_ext    = st;
    bus.id_valid = v;
    bus.PC_addr    = pc;
    bus.read_data1 = pc << 1;
    bus.read_data2 = pc << 2;
    bus.imm_val    = pc >> 1;
    bus.funct_in   = pc[3:0];
    bus.ALU_op     = alu;
    bus.rd_in      = rd;
    bus.rs1_in     = rs1;
    bus.rs2_in     = rs2;
    {bus.MemtoReg, bus.RegWrite, bus.Branch, bus.MemWrite, bus.MemRead, bus.ALUSrc} = ctl;
    r.idx  = step_no;
    r.last = 1'b0;
    r.lu   = e_lu;
    r.hold = e_hold;
    r.ev   = e_ev;
    r.pc   = e_pc;
    r.rd   = e_rd;
    r.ctl  = e_ctl;
    r.alu  = e_alu;
    r.bc   = 16'(e_bc);
    r.fc   = 16'(e_fc);
    r.fcs  = 2'(e_fcs);
    exp_q.push_back(r);
    step_no++;
  endtask

  // Monitor: comb outputs checked against the current record, registered
  // outputs against the previous record's post-edge expectation.
  initial begin : monitor
    exp_t r;
    exp_t prev;
    logic [5:0] ctl_act;
    prev = '{idx: -1, last: 1'b0, lu: 1'b0, hold: 1'b0, ev: 1'b0, pc: 64'h0, rd: 5'h0,
             ctl: 6'h0, alu: 2'h0, bc: 16'h0, fc: 16'h0, fcs: 2'h0};
    while (!mon_done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        ctl_act = {bus.MemtoReg_store, bus.RegWrite_store, bus.Branch_store,
                   bus.MemWrite_store, bus.MemRead_store, bus.ALUSrc_store};
        chk("ex_valid",   prev.idx, 64'(bus.ex_valid),         64'(prev.ev));
        chk("pc_store",   prev.idx, bus.PC_addr_store,         prev.pc);
        chk("rdata1",     prev.idx, bus.read_data1_store,      prev.pc << 1);
        chk("imm_store",  prev.idx, bus.imm_val_store,         prev.pc >> 1);
        chk("rd_store",   prev.idx, 64'(bus.rd_in_store),      64'(prev.rd));
        chk("ctl_store",  prev.idx, 64'(ctl_act),              64'(prev.ctl));
        chk("alu_store",  prev.idx, 64'(bus.ALU_op_store),     64'(prev.alu));
        chk("bubble_cnt", prev.idx, 64'(bubble_cnt),           64'(prev.bc));
        chk("flush_cnt",  prev.idx, 64'(flush_cnt),            64'(prev.fc));
        chk("flush_sat",  prev.idx, 64'(flush_s),              64'(prev.fcs));
        if (!r.last) begin
          chk("load_use",      r.idx, 64'(load_use),      64'(r.lu));
          chk("hold_upstream", r.idx, 64'(hold_upstream), 64'(r.hold));
        end
        $display("txn step=%0d pc_store=%0h ex_valid=%0b load_use=%0b hold=%0b bc=%0d fc=%0d",
                 prev.idx, bus.PC_addr_store, bus.ex_valid, load_use, hold_upstream,
                 bubble_cnt, flush_cnt);
        prev = r;
        if (r.last) mon_done = 1'b1;
      end
    end
  end

  initial begin : driver
    exp_t r;
    reset = 1'b1;
    flush = 1'b0;
    stall_ext = 1'b0;
    bus.id_valid = 1'b0;
    bus.PC_addr = '0; bus.read_data1 = '0; bus.read_data2 = '0; bus.imm_val = '0;
    bus.funct_in = '0; bus.ALU_op = '0; bus.rd_in = '0; bus.rs1_in = '0; bus.rs2_in = '0;
    {bus.MemtoReg, bus.RegWrite, bus.Branch, bus.MemWrite, bus.MemRead, bus.ALUSrc} = '0;
    repeat (2) @(posedge clk);

    //   rst fl st v  pc      rd rs1 rs2 ctl        alu  lu hold  ev pc      rd ctl        alu  bc fc fcs
    step(0, 0, 0, 1, 'h100,  5, 1,  2,  6'b010000, 2,   0, 0,    1, 'h100,  5, 6'b010000, 2,   0, 0, 0); // basic load
    step(1, 0, 1, 1, 'h200,  3, 1,  2,  6'b110011, 1,   0, 1,    0, 'h0,    0, 6'b000000, 0,   0, 0, 0); // reset beats stall
    step(0, 0, 0, 1, 'h300,  7, 1,  2,  6'b110011, 0,   0, 0,    1, 'h300,  7, 6'b110011, 0,   0, 0, 0); // load into x7
    step(0, 0, 0, 1, 'h304,  8, 3,  7,  6'b010000, 2,   1, 1,    0, 'h304,  8, 6'b000000, 0,   1, 0, 0); // rs2 hazard -> bubble
    step(0, 0, 0, 1, 'h304,  8, 3,  7,  6'b010000, 2,   0, 0,    1, 'h304,  8, 6'b010000, 2,   1, 0, 0); // one bubble only
    step(0, 0, 0, 1, 'h400,  0, 1,  2,  6'b110011, 0,   0, 0,    1, 'h400,  0, 6'b110011, 0,   1, 0, 0); // load into x0
    step(0, 0, 0, 1, 'h404,  9, 0,  0,  6'b010000, 3,   0, 0,    1, 'h404,  9, 6'b010000, 3,   1, 0, 0); // x0 no hazard
    step(0, 0, 0, 1, 'h500,  7, 1,  2,  6'b110011, 0,   0, 0,    1, 'h500,  7, 6'b110011, 0,   1, 0, 0); // load into x7
    step(0, 1, 0, 1, 'h504,  8, 3,  7,  6'b010000, 2,   1, 0,    0, 'h0,    0, 6'b000000, 0,   1, 1, 1); // flush beats hazard
    step(0, 0, 0, 1, 'h600, 10, 1,  2,  6'b010001, 1,   0, 0,    1, 'h600, 10, 6'b010001, 1,   1, 1, 1); // load
    step(0, 0, 1, 1, 'h610, 11, 1,  2,  6'b110011, 2,   0, 1,    1, 'h600, 10, 6'b010001, 1,   1, 1, 1); // hold 1
    step(0, 0, 1, 0, 'h620, 12, 1,  2,  6'b000100, 3,   0, 1,    1, 'h600, 10, 6'b010001, 1,   1, 1, 1); // hold 2
    step(0, 0, 1, 1, 'h630, 13, 10, 2,  6'b010000, 0,   0, 1,    1, 'h600, 10, 6'b010001, 1,   1, 1, 1); // hold 3
    step(0, 0, 0, 1, 'h640, 14, 1,  2,  6'b110011, 2,   0, 0,    1, 'h640, 14, 6'b110011, 2,   1, 1, 1); // release captures
    step(0, 0, 1, 1, 'h650, 15, 14, 2,  6'b010000, 1,   1, 1,    1, 'h640, 14, 6'b110011, 2,   1, 1, 1); // stall+hazard holds
    step(0, 0, 0, 1, 'h650, 15, 14, 2,  6'b010000, 1,   1, 1,    0, 'h650, 15, 6'b000000, 0,   2, 1, 1); // then bubble
    step(0, 0, 0, 1, 'h650, 15, 14, 2,  6'b010000, 1,   0, 0,    1, 'h650, 15, 6'b010000, 1,   2, 1, 1); // then load
    step(0, 0, 0, 0, 'h700, 16, 0,  0,  6'b111111, 3,   0, 0,    0, 'h700, 16, 6'b000000, 3,   2, 1, 1); // invalid: ctl forced 0
    step(0, 1, 1, 1, 'h800,  1, 1,  2,  6'b110011, 1,   0, 0,    0, 'h0,    0, 6'b000000, 0,   2, 2, 2); // flush beats stall
    step(0, 1, 0, 1, 'h810,  1, 1,  2,  6'b110011, 1,   0, 0,    0, 'h0,    0, 6'b000000, 0,   2, 3, 3); // flush 3
    step(0, 1, 0, 1, 'h820,  1, 1,  2,  6'b110011, 1,   0, 0,    0, 'h0,    0, 6'b000000, 0,   2, 4, 3); // CNTW=2 saturates
    step(0, 1, 0, 1, 'h830,  1, 1,  2,  6'b110011, 1,   0, 0,    0, 'h0,    0, 6'b000000, 0,   2, 5, 3); // stays saturated
    step(0, 0, 0, 1, 'h880,  3, 1,  2,  6'b010000, 1,   0, 0,    1, 'h880,  3, 6'b010000, 1,   2, 5, 3); // load
    step(1, 0, 1, 1, 'h900,  4, 3,  3,  6'b110011, 2,   0, 1,    0, 'h0,    0, 6'b000000, 0,   0, 0, 0); // reset mid-stall

    @(posedge clk);
    #1;
    reset = 1'b0;
    stall_ext = 1'b0;
    r = '{idx: step_no, last: 1'b1, lu: 1'b0, hold: 1'b0, ev: 1'b0, pc: 64'h0, rd: 5'h0,
          ctl: 6'h0, alu: 2'h0, bc: 16'h0, fc: 16'h0, fcs: 2'h0};
    exp_q.push_back(r);

    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout actual=%0d queued required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter XLEN, default 64, data/PC/immediate width.
REQ-002 Parameter REGW, default 5, register-index width.
REQ-003 Parameter FUNCTW, default 4, funct field width; ALUOPW, default 2, ALU_op width.
REQ-004 Parameter CNTW, default 16, width of bubble and flush counters.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  kill instruction entering EX (branch taken).
REQ-008 stall_ext  in  1  downstream hold; EX register keeps its contents.
REQ-009 id_valid  in  1  ID-side instruction present.
REQ-010 PC_addr, read_data1, read_data2, imm_val  in  XLEN each  ID datapath.
REQ-011 funct_in  in  FUNCTW;  ALU_op  in  ALUOPW;  rd_in, rs1_in, rs2_in  in  REGW each.
REQ-012 MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc  in  1 each  ID control.
REQ-013 *_store outputs  out  matching widths  registered copies of every REQ-010..012 input.
REQ-014 ex_valid  out  1  EX register holds a live instruction.
REQ-015 hold_upstream  out  1  combinational; PC and IF/ID registers must not advance.
REQ-016 load_use  out  1  combinational; load-use hazard detected this cycle.
REQ-017 bubble_cnt, flush_cnt  out  CNTW each  saturating event counters.

Function
REQ-018 load_use SHALL = ex_valid & MemRead_store & id_valid & (rd_in_store != 0) & ((rd_in_store == rs1_in) | (rd_in_store == rs2_in)).
REQ-019 hold_upstream SHALL = (stall_ext | load_use) & ~flush.
REQ-020 Per-edge action priority SHALL be: reset > flush > stall_ext > load_use > load.
REQ-021 Flush: all *_store outputs and ex_valid SHALL become 0 next cycle; flush_cnt increments.
REQ-022 Hold (stall_ext=1, no flush): every register, including ex_valid, SHALL keep its value; counters unchanged.
REQ-023 Bubble (load_use=1, stall_ext=0, no flush): control *_store bits, ALU_op_store and ex_valid SHALL be 0; datapath *_store fields SHALL be loaded from inputs; bubble_cnt increments.
REQ-024 Load (none of above): every *_store SHALL capture its input; ex_valid SHALL capture id_valid.
REQ-025 Load with id_valid=0: control *_store bits SHALL be forced to 0 so no invalid instruction writes register file or memory.
REQ-026 Latency SHALL be exactly one cycle input-to-*_store on Load.
REQ-027 Counters SHALL saturate at 2^CNTW-1 and never wrap.
REQ-028 load_use SHALL deassert the cycle after a bubble since ex_valid is then 0; a load-use therefore costs exactly one bubble.
REQ-029 Simultaneous flush and load_use: flush wins, only flush_cnt increments, hold_upstream=0.
REQ-030 Simultaneous stall_ext and load_use: hold, no bubble counted; bubble occurs after stall_ext drops if hazard persists.

Reset
REQ-031 On reset, every *_store output, ex_valid, bubble_cnt and flush_cnt SHALL be 0 at the next edge.
REQ-032 Reset SHALL override flush, stall_ext and load_use in the same cycle; mid-stall reset clears held contents.
REQ-033 No output SHALL depend on an uninitialised register after the first reset edge.

Verification
REQ-034 Load: id_valid=1, PC_addr=0x100, rd_in=5, RegWrite=1 -> next cycle PC_addr_store=0x100, rd_in_store=5, RegWrite_store=1, ex_valid=1.
REQ-035 Load-use: EX holds MemRead_store=1, rd_in_store=7; ID rs2_in=7 -> load_use=1, hold_upstream=1; next cycle ex_valid=0, control zero, bubble_cnt=1, load_use=0.
REQ-036 x0 hazard: EX MemRead_store=1, rd_in_store=0, ID rs1_in=0 -> load_use=0, normal load.
REQ-037 Flush+hazard: REQ-035 setup plus flush=1 -> hold_upstream=0; next cycle all *_store=0, flush_cnt=1, bubble_cnt unchanged.
REQ-038 Hold: stall_ext=1 for 3 cycles with changing inputs -> *_store constant; on release, next cycle captures current inputs.
REQ-039 Saturation/reset: CNTW=2, 5 flushes -> flush_cnt=3; then reset=1 with stall_ext=1 -> all outputs 0 next cycle.
